// File: rtl/alu_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : alu_pipe_if                                               |
// | Brief  : Request/result handshake bundle for alu_pipe.             |
// |          The ALU sits on the slave side, its client on the master  |
// |          side.                                                     |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
interface alu_pipe_if #(
  parameter int NB_DATA   = 8,
  parameter int NB_OPCODE = 6,
  parameter int NB_CNT    = 16
);
  // Request side
  logic                 i_valid;
  logic                 o_ready;
  logic [NB_DATA-1:0]   i_op_1;
  logic [NB_DATA-1:0]   i_op_2;
  logic [NB_OPCODE-1:0] i_opcode;
  // Result side
  logic                 o_valid;
  logic                 i_ready;
  logic [NB_DATA-1:0]   o_result;
  logic [3:0]           o_flags;
  // Status
  logic                 o_illegal;
  logic [NB_CNT-1:0]    o_op_count;

  modport master (
    output i_valid, i_op_1, i_op_2, i_opcode, i_ready,
    input  o_ready, o_valid, o_result, o_flags, o_illegal, o_op_count
  );

  modport slave (
    input  i_valid, i_op_1, i_op_2, i_opcode, i_ready,
    output o_ready, o_valid, o_result, o_flags, o_illegal, o_op_count
  );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : alu_pipe                                                  |
// | Brief  : Single-stage registered ALU with valid/ready handshake,   |
// |          arithmetic flags, sticky illegal-opcode flag and an       |
// |          accepted-operation counter.                               |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module alu_pipe #(
  parameter int NB_DATA   = 8,
  parameter int NB_OPCODE = 6,
  parameter int NB_CNT    = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  alu_pipe_if.slave  bus
);

  localparam int c_MSB = NB_DATA - 1;

  localparam logic [NB_OPCODE-1:0] c_OP_ADD = NB_OPCODE'(6'b100000);
  localparam logic [NB_OPCODE-1:0] c_OP_SUB = NB_OPCODE'(6'b100010);
  localparam logic [NB_OPCODE-1:0] c_OP_AND = NB_OPCODE'(6'b100100);
  localparam logic [NB_OPCODE-1:0] c_OP_OR  = NB_OPCODE'(6'b100101);
  localparam logic [NB_OPCODE-1:0] c_OP_XOR = NB_OPCODE'(6'b100110);
  localparam logic [NB_OPCODE-1:0] c_OP_NOR = NB_OPCODE'(6'b100111);
  localparam logic [NB_OPCODE-1:0] c_OP_SRL = NB_OPCODE'(6'b000010);
  localparam logic [NB_OPCODE-1:0] c_OP_SRA = NB_OPCODE'(6'b000011);

  // Shift amounts at or beyond the operand width saturate to fill bits.
  localparam logic [NB_DATA-1:0] c_SHIFT_LIMIT = NB_DATA'(NB_DATA);

  logic               r_valid;
  logic [NB_DATA-1:0] r_result;
  logic [3:0]         r_flags;
  logic               r_illegal;
  logic [NB_CNT-1:0]  r_count;

  logic               w_ready;
  logic               w_accept;
  logic [NB_DATA-1:0] w_a;
  logic [NB_DATA-1:0] w_b;
  logic [NB_DATA:0]   w_sum;
  logic [NB_DATA:0]   w_diff;
  logic               w_shift_big;
  logic [NB_DATA-1:0] w_result;
  logic               w_carry;
  logic               w_overflow;
  logic               w_illegal;
  logic [3:0]         w_flags;

  // A slot is free when the output is empty or is being drained this cycle.
  assign w_ready  = !r_valid || bus.i_ready;
  assign w_accept = bus.i_valid && w_ready;

  assign w_a         = bus.i_op_1;
  assign w_b         = bus.i_op_2;
  assign w_sum       = {1'b0, w_a} + {1'b0, w_b};
  // The extra top bit of the unsigned difference is the borrow (a < b).
  assign w_diff      = {1'b0, w_a} - {1'b0, w_b};
  assign w_shift_big = (w_b >= c_SHIFT_LIMIT);

  // Opcode decode and result/flag computation for the incoming request.
  always_comb begin
    w_result   = '0;
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    w_illegal  = 1'b0;
    w_flags    = 4'b0000;
    case (bus.i_opcode)
      c_OP_ADD: begin
        w_result   = w_sum[NB_DATA-1:0];
        w_carry    = w_sum[NB_DATA];
        w_overflow = (w_a[c_MSB] == w_b[c_MSB]) && (w_result[c_MSB] != w_a[c_MSB]);
      end
      c_OP_SUB: begin
        w_result   = w_diff[NB_DATA-1:0];
        w_carry    = w_diff[NB_DATA];
        w_overflow = (w_a[c_MSB] != w_b[c_MSB]) && (w_result[c_MSB] != w_a[c_MSB]);
      end
      c_OP_AND: w_result = w_a & w_b;
      c_OP_OR:  w_result = w_a | w_b;
      c_OP_XOR: w_result = w_a ^ w_b;
      c_OP_NOR: w_result = ~(w_a | w_b);
      c_OP_SRL: w_result = w_shift_big ? '0 : (w_a >> w_b);
      c_OP_SRA: w_result = w_shift_big ? {NB_DATA{w_a[c_MSB]}}
                                       : NB_DATA'($signed(w_a) >>> w_b);
      default:  w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_flags = 4'b0001;
    end else begin
      w_flags = {w_carry, w_overflow, w_result[c_MSB], (w_result == '0)};
    end
  end

  // Output register: load on accept, drop valid on a drain with no refill.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_flags   <= 4'b0000;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_result  <= w_result;
      r_flags   <= w_flags;
      r_illegal <= r_illegal | w_illegal;
      r_count   <= r_count + NB_CNT'(1);
    end else if (bus.i_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign bus.o_ready    = w_ready;
  assign bus.o_valid    = r_valid;
  assign bus.o_result   = r_result;
  assign bus.o_flags    = r_flags;
  assign bus.o_illegal  = r_illegal;
  assign bus.o_op_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_alu_pipe                                               |
// | Brief  : Scoreboard bench for alu_pipe with directed vectors.      |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module tb_alu_pipe;

  localparam logic [5:0] c_ADD = 6'b100000;
  localparam logic [5:0] c_SUB = 6'b100010;
  localparam logic [5:0] c_AND = 6'b100100;
  localparam logic [5:0] c_OR  = 6'b100101;
  localparam logic [5:0] c_XOR = 6'b100110;
  localparam logic [5:0] c_NOR = 6'b100111;
  localparam logic [5:0] c_SRL = 6'b000010;
  localparam logic [5:0] c_SRA = 6'b000011;
  localparam logic [5:0] c_BAD = 6'b111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_pipe_if #(.NB_DATA(8), .NB_OPCODE(6), .NB_CNT(16)) bus ();
  alu_pipe_if #(.NB_DATA(8), .NB_OPCODE(6), .NB_CNT(4))  bus2 ();

  alu_pipe #(.NB_DATA(8), .NB_OPCODE(6), .NB_CNT(16)) u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  alu_pipe #(.NB_DATA(8), .NB_OPCODE(6), .NB_CNT(4)) u_dut_cnt4 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_pop    = 0;
  logic [11:0] q_exp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a result transfers at the next edge when o_valid && i_ready.
  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst && bus.o_valid && bus.i_ready) begin
      if (q_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%0h with empty scoreboard", bus.o_result);
      end else begin
        e = q_exp.pop_front();
        n_pop++;
        chk("result", {24'h0, bus.o_result}, {24'h0, e[11:4]});
        chk("flags",  {28'h0, bus.o_flags},  {28'h0, e[3:0]});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                       input logic [7:0] er, input logic [3:0] ef);
    int waitc;
    waitc = 0;
    bus.i_valid  = 1'b1;
    bus.i_op_1   = a;
    bus.i_op_2   = b;
    bus.i_opcode = op;
    @(negedge clk);
    while (!bus.o_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.o_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: o_ready stayed 0 for op 0x%0h", op);
    end else begin
      q_exp.push_back({er, ef});
      n_acc++;
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pop0;
    bus.i_valid  = 1'b0;
    bus.i_ready  = 1'b1;
    bus.i_op_1   = '0;
    bus.i_op_2   = '0;
    bus.i_opcode = '0;
    bus2.i_valid  = 1'b0;
    bus2.i_ready  = 1'b1;
    bus2.i_op_1   = '0;
    bus2.i_op_2   = '0;
    bus2.i_opcode = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    settle();
    chk("rst_valid",   {31'h0, bus.o_valid},   32'h0);
    chk("rst_result",  {24'h0, bus.o_result},  32'h0);
    chk("rst_flags",   {28'h0, bus.o_flags},   32'h0);
    chk("rst_illegal", {31'h0, bus.o_illegal}, 32'h0);
    chk("rst_count",   {16'h0, bus.o_op_count}, 32'h0);
    chk("rst_ready",   {31'h0, bus.o_ready},   32'h1);
    realign();

    // Ten back-to-back requests with full throughput
    pop0 = n_pop;
    issue(8'h7F, 8'h01, c_ADD, 8'h80, 4'b0110);
    issue(8'h00, 8'h01, c_SUB, 8'hFF, 4'b1010);
    issue(8'h80, 8'h03, c_SRA, 8'hF0, 4'b0010);
    issue(8'h80, 8'h03, c_SRL, 8'h10, 4'b0000);
    issue(8'h80, 8'h09, c_SRA, 8'hFF, 4'b0010);
    issue(8'h80, 8'h09, c_SRL, 8'h00, 4'b0001);
    issue(8'hF0, 8'h3C, c_AND, 8'h30, 4'b0000);
    issue(8'hF0, 8'h0F, c_OR,  8'hFF, 4'b0010);
    issue(8'hAA, 8'hAA, c_XOR, 8'h00, 4'b0001);
    issue(8'h00, 8'h00, c_NOR, 8'hFF, 4'b0010);
    settle();
    chk("b2b_results", n_pop - pop0, 32'd10);
    chk("b2b_count", {16'h0, bus.o_op_count}, 32'd10);
    realign();

    // Carry/overflow corner cases
    issue(8'hFF, 8'h01, c_ADD, 8'h00, 4'b1001);
    issue(8'h80, 8'h01, c_SUB, 8'h7F, 4'b0100);
    issue(8'h80, 8'h80, c_ADD, 8'h00, 4'b1101);
    issue(8'h05, 8'h05, c_SUB, 8'h00, 4'b0001);
    realign();

    // Stall: result held, waiting request not accepted
    bus.i_ready = 1'b0;
    issue(8'h01, 8'h02, c_ADD, 8'h03, 4'b0000);
    bus.i_valid  = 1'b1;
    bus.i_op_1   = 8'h10;
    bus.i_op_2   = 8'h01;
    bus.i_opcode = c_SUB;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("stall_ready",  {31'h0, bus.o_ready},  32'h0);
      chk("stall_valid",  {31'h0, bus.o_valid},  32'h1);
      chk("stall_result", {24'h0, bus.o_result}, 32'h03);
      chk("stall_flags",  {28'h0, bus.o_flags},  32'h0);
      realign();
    end
    chk("stall_count", {16'h0, bus.o_op_count}, n_acc);
    bus.i_ready = 1'b1;
    issue(8'h10, 8'h01, c_SUB, 8'h0F, 4'b0000);
    realign();

    // Illegal opcode and stickiness
    issue(8'h12, 8'h34, c_BAD, 8'h00, 4'b0001);
    settle();
    chk("illegal_set", {31'h0, bus.o_illegal}, 32'h1);
    realign();
    issue(8'h01, 8'h01, c_ADD, 8'h02, 4'b0000);
    settle();
    chk("illegal_sticky", {31'h0, bus.o_illegal}, 32'h1);
    chk("count_total", {16'h0, bus.o_op_count}, n_acc);
    chk("scoreboard_drained", q_exp.size(), 32'd0);
    realign();

    // Reset while a result is stalled
    bus.i_ready = 1'b0;
    issue(8'h05, 8'h06, c_ADD, 8'h0B, 4'b0000);
    bus.i_valid  = 1'b1;
    bus.i_op_1   = 8'h22;
    bus.i_op_2   = 8'h11;
    bus.i_opcode = c_ADD;
    rst = 1'b1;
    realign();
    rst = 1'b0;
    bus.i_valid = 1'b0;
    q_exp.delete();
    n_acc = 0;
    settle();
    chk("rst2_valid",   {31'h0, bus.o_valid},   32'h0);
    chk("rst2_result",  {24'h0, bus.o_result},  32'h0);
    chk("rst2_flags",   {28'h0, bus.o_flags},   32'h0);
    chk("rst2_illegal", {31'h0, bus.o_illegal}, 32'h0);
    chk("rst2_count",   {16'h0, bus.o_op_count}, 32'h0);
    chk("rst2_ready",   {31'h0, bus.o_ready},   32'h1);
    realign();
    bus.i_ready = 1'b1;

    // 4-bit counter wraps after 16 accepts
    bus2.i_valid  = 1'b1;
    bus2.i_opcode = c_ADD;
    bus2.i_op_1   = 8'h03;
    bus2.i_op_2   = 8'h04;
    repeat (17) @(posedge clk);
    #1;
    bus2.i_valid = 1'b0;
    settle();
    chk("cnt4_wrap",   {28'h0, bus2.o_op_count}, 32'd1);
    chk("cnt4_result", {24'h0, bus2.o_result},   32'h07);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
